// File: rtl/irf_window_swap_seq.sv
// Window-swap sequencer: queues save/restore requests and drives the
// register-file window backing store with correctly spaced strobes.
module irf_window_swap_seq #(
   parameter int unsigned DEPTH  = 2,
   parameter int unsigned SLOT_W = 3
) (
   input  logic              clk,
   input  logic              arst_l,
   input  logic              req_vld,
   output logic              req_rdy,
   input  logic [1:0]        req_thr,
   input  logic [1:0]        req_op,
   input  logic [SLOT_W-1:0] req_save_slot,
   input  logic [SLOT_W-1:0] req_rest_slot,
   output logic              save,
   output logic [SLOT_W+1:0] save_addr,
   output logic              restore,
   output logic [SLOT_W+1:0] restore_addr,
   output logic [3:0]        thr_stall,
   output logic              done,
   output logic [1:0]        done_thr
);

   localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW     = $clog2(DEPTH) + 1;
   localparam int unsigned ADDR_W = SLOT_W + 2;

   localparam logic [1:0] OP_SAVE = 2'b01;
   localparam logic [1:0] OP_REST = 2'b10;
   localparam logic [1:0] OP_SWAP = 2'b11;

   typedef struct packed {
      logic [1:0]        thr;
      logic [1:0]        op;
      logic [SLOT_W-1:0] save_slot;
      logic [SLOT_W-1:0] rest_slot;
   } req_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SAVE,
      ST_SWAIT,
      ST_REST,
      ST_DONE
   } state_e;

   req_t          fifo_mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] cnt_q;
   logic          push, pop;
   req_t          req_in, head;

   state_e        state_q, state_d;
   req_t          req_q, req_d;

   logic              save_q, save_d;
   logic              restore_q, restore_d;
   logic              done_q, done_d;
   logic [ADDR_W-1:0] save_addr_q, save_addr_d;
   logic [ADDR_W-1:0] restore_addr_q, restore_addr_d;
   logic [3:0]        stall_q, stall_d;
   logic [1:0]        done_thr_q, done_thr_d;

   assign req_in  = '{thr: req_thr, op: req_op, save_slot: req_save_slot, rest_slot: req_rest_slot};
   assign req_rdy = (cnt_q < CW'(DEPTH));
   assign push    = req_vld & req_rdy;
   assign pop     = (state_q == ST_IDLE) && (cnt_q != '0);
   assign head    = fifo_mem[rd_ptr_q];

   // Request storage; contents need no reset since the count gates use.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= req_in;
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge arst_l) begin
      if (!arst_l) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // State, captured request and registered outputs.
   always_ff @(posedge clk or negedge arst_l) begin
      if (!arst_l) begin
         state_q        <= ST_IDLE;
         req_q          <= '0;
         save_q         <= 1'b0;
         restore_q      <= 1'b0;
         done_q         <= 1'b0;
         save_addr_q    <= '0;
         restore_addr_q <= '0;
         stall_q        <= '0;
         done_thr_q     <= '0;
      end else begin
         state_q        <= state_d;
         req_q          <= req_d;
         save_q         <= save_d;
         restore_q      <= restore_d;
         done_q         <= done_d;
         save_addr_q    <= save_addr_d;
         restore_addr_q <= restore_addr_d;
         stall_q        <= stall_d;
         done_thr_q     <= done_thr_d;
      end
   end

   // Next state plus output decode from the upcoming state, so outputs are flops.
   always_comb begin
      state_d        = state_q;
      req_d          = req_q;
      save_d         = 1'b0;
      restore_d      = 1'b0;
      done_d         = 1'b0;
      save_addr_d    = save_addr_q;
      restore_addr_d = restore_addr_q;
      stall_d        = '0;
      done_thr_d     = done_thr_q;

      case (state_q)
         ST_IDLE: begin
            if (pop) begin
               req_d = head;
               case (head.op)
                  OP_SAVE, OP_SWAP: state_d = ST_SAVE;
                  OP_REST:          state_d = ST_REST;
                  default:          state_d = ST_DONE;
               endcase
            end
         end
         ST_SAVE:  state_d = ST_SWAIT;
         // One bubble lets the store finish its delayed, negedge-written save.
         ST_SWAIT: state_d = (req_q.op == OP_SWAP) ? ST_REST : ST_DONE;
         ST_REST:  state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      case (state_d)
         ST_SAVE: begin
            save_d      = 1'b1;
            save_addr_d = {req_d.thr, req_d.save_slot};
         end
         ST_REST: begin
            restore_d      = 1'b1;
            restore_addr_d = {req_d.thr, req_d.rest_slot};
         end
         ST_DONE: begin
            done_d     = 1'b1;
            done_thr_d = req_d.thr;
         end
         default: ;
      endcase

      if ((state_d == ST_SAVE) || (state_d == ST_SWAIT) || (state_d == ST_REST)) begin
         stall_d[req_d.thr] = 1'b1;
      end
   end

   assign save         = save_q;
   assign save_addr    = save_addr_q;
   assign restore      = restore_q;
   assign restore_addr = restore_addr_q;
   assign thr_stall    = stall_q;
   assign done         = done_q;
   assign done_thr     = done_thr_q;

endmodule

// File: tb/tb_irf_window_swap_seq.sv
// Scoreboard bench for irf_window_swap_seq: stimulus queues expected strobes,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_irf_window_swap_seq;

   localparam int unsigned SLOT_W = 3;

   logic              clk;
   logic              arst_l;
   logic              req_vld;
   logic              req_rdy;
   logic [1:0]        req_thr;
   logic [1:0]        req_op;
   logic [SLOT_W-1:0] req_save_slot;
   logic [SLOT_W-1:0] req_rest_slot;
   logic              save;
   logic [SLOT_W+1:0] save_addr;
   logic              restore;
   logic [SLOT_W+1:0] restore_addr;
   logic [3:0]        thr_stall;
   logic              done;
   logic [1:0]        done_thr;

   irf_window_swap_seq #(.DEPTH(2), .SLOT_W(SLOT_W)) dut (
      .clk           (clk),
      .arst_l        (arst_l),
      .req_vld       (req_vld),
      .req_rdy       (req_rdy),
      .req_thr       (req_thr),
      .req_op        (req_op),
      .req_save_slot (req_save_slot),
      .req_rest_slot (req_rest_slot),
      .save          (save),
      .save_addr     (save_addr),
      .restore       (restore),
      .restore_addr  (restore_addr),
      .thr_stall     (thr_stall),
      .done          (done),
      .done_thr      (done_thr)
   );

   // kind: 0 save, 1 restore, 2 done; cyc < 0 means timing not checked
   typedef struct {
      int kind;
      int val;
      int stall;
      int cyc;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   function automatic void add_ev(input int kind, input int val, input int stall, input int c);
      ev_t e;
      e.kind  = kind;
      e.val   = val;
      e.stall = stall;
      e.cyc   = c;
      exp_q.push_back(e);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_ev(input int kind, input int val);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: kind %0d val %0h at cycle %0d, nothing expected", kind, val, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.val != val || e.stall != int'(thr_stall) ||
             (e.cyc >= 0 && e.cyc != cyc)) begin
            errors++;
            $display("FAIL event: got kind %0d val %0h stall %0h cyc %0d, expected kind %0d val %0h stall %0h cyc %0d",
                     kind, val, thr_stall, cyc, e.kind, e.val, e.stall, e.cyc);
         end
      end
   endtask

   // Monitor: compare every strobe the DUT presents against the scoreboard head.
   always @(negedge clk) begin
      if (arst_l) begin
         if (save && restore) begin
            checks++;
            errors++;
            $display("FAIL strobe_excl: save and restore both high at cycle %0d", cyc);
         end
         if ($countones(thr_stall) > 1) begin
            checks++;
            errors++;
            $display("FAIL stall_onehot: thr_stall %b at cycle %0d", thr_stall, cyc);
         end
         if (save)    check_ev(0, int'(save_addr));
         if (restore) check_ev(1, int'(restore_addr));
         if (done)    check_ev(2, int'(done_thr));
      end
   end

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic push_req(input int thr, input int op, input int ss, input int rs, input bit timed);
      int  n;
      int  waits;
      int  stl;
      bit  acc;
      req_vld       = 1'b1;
      req_thr       = 2'(thr);
      req_op        = 2'(op);
      req_save_slot = SLOT_W'(ss);
      req_rest_slot = SLOT_W'(rs);
      acc   = 1'b0;
      waits = 0;
      n     = 0;
      while (!acc && waits < 50) begin
         acc = req_rdy;
         n   = cyc;
         @(posedge clk);
         @(negedge clk);
         waits++;
      end
      req_vld = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: thr %0d op %0d never accepted", thr, op);
      end else begin
         stl = 1 << thr;
         case (op)
            1: begin
               add_ev(0, thr * 8 + ss, stl, timed ? n + 2 : -1);
               add_ev(2, thr,          0,   timed ? n + 4 : -1);
            end
            3: begin
               add_ev(0, thr * 8 + ss, stl, timed ? n + 2 : -1);
               add_ev(1, thr * 8 + rs, stl, timed ? n + 4 : -1);
               add_ev(2, thr,          0,   timed ? n + 5 : -1);
            end
            2: begin
               add_ev(1, thr * 8 + rs, stl, timed ? n + 2 : -1);
               add_ev(2, thr,          0,   timed ? n + 3 : -1);
            end
            default: add_ev(2, thr, 0, timed ? n + 2 : -1);
         endcase
      end
   endtask

   task automatic wait_drain(input string name);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk(name, 32'(exp_q.size()), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_save"},         32'(save),         32'd0);
      chk({tag, "_restore"},      32'(restore),      32'd0);
      chk({tag, "_done"},         32'(done),         32'd0);
      chk({tag, "_stall"},        32'(thr_stall),    32'd0);
      chk({tag, "_save_addr"},    32'(save_addr),    32'd0);
      chk({tag, "_restore_addr"}, 32'(restore_addr), 32'd0);
      chk({tag, "_done_thr"},     32'(done_thr),     32'd0);
   endtask

   initial begin
      arst_l        = 1'b1;
      req_vld       = 1'b0;
      req_thr       = '0;
      req_op        = '0;
      req_save_slot = '0;
      req_rest_slot = '0;

      // Reset mid-cycle, then idle
      @(negedge clk);
      #2 arst_l = 1'b0;
      #1 chk_all_zero("reset");
      repeat (2) @(negedge clk);
      arst_l = 1'b1;
      chk("rdy_after_reset", 32'(req_rdy), 32'd1);
      repeat (20) @(negedge clk);

      // Single save-then-restore: thr2, save 5 (0x15), rest 6 (0x16)
      push_req(2, 3, 5, 6, 1'b1);
      wait_drain("drain_swap");

      // Back-to-back: FSM busy with a swap, three save-only requests behind it
      push_req(2, 3, 1, 2, 1'b0);
      push_req(0, 1, 4, 0, 1'b0);
      push_req(1, 1, 4, 0, 1'b0);
      chk("rdy_full", 32'(req_rdy), 32'd0);
      push_req(3, 1, 4, 0, 1'b0);
      wait_drain("drain_b2b");

      // Restore-only (thr3 slot7 -> 0x1F), then null op on thr2
      push_req(3, 2, 0, 7, 1'b1);
      wait_drain("drain_rest");
      push_req(2, 0, 0, 0, 1'b1);
      wait_drain("drain_null");

      // Same-slot swap: thr1, slot 3 both ways -> 0x0B two cycles apart
      push_req(1, 3, 3, 3, 1'b1);
      wait_drain("drain_same");

      // Reset during SWAIT with one request queued
      push_req(1, 3, 2, 5, 1'b1);
      push_req(0, 1, 6, 0, 1'b0);
      @(negedge clk);
      chk("stall_in_swait", 32'(thr_stall), 32'h2);
      #2 arst_l = 1'b0;
      #1 chk_all_zero("reset_swait");
      exp_q.delete();
      repeat (2) @(negedge clk);
      arst_l = 1'b1;
      chk("rdy_after_abort", 32'(req_rdy), 32'd1);
      repeat (10) @(negedge clk);
      push_req(2, 1, 7, 0, 1'b1);
      wait_drain("drain_after_abort");

      repeat (5) @(negedge clk);
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
